// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
//   ctrl_state_t : sequencer states
//   pcsel_t      : PC-source select driven to the datapath
//   exc_cause_t  : latched exception cause
//   EXC_VECTOR   : exception handler address selected by PC_EXC
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MEM_WAIT  = 2'd1,
    EXC_FLUSH = 2'd2,
    EXC_REDIR = 2'd3
  } ctrl_state_t;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_JUMP   = 2'd1,
    PC_BRANCH = 2'd2,
    PC_EXC    = 2'd3
  } pcsel_t;

  typedef enum logic [1:0] {
    EXC_NONE  = 2'd0,
    EXC_BADOP = 2'd1,
    EXC_OVF   = 2'd2,
    EXC_BUS   = 2'd3
  } exc_cause_t;

  localparam logic [31:0] EXC_VECTOR = 32'h8000_0000;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline status/control bundle between datapath and hazard controller.
//   master : controller side (consumes status, drives stall/clear/pc_sel/epc/cause)
//   slave  : datapath side (drives status, consumes controls)
// PERF_CNT_EN adds perf_stall/perf_flush/perf_exc (PERF_W bits each).
interface pipe_hazard_ctrl_if
`ifdef PERF_CNT_EN
  #(parameter int unsigned PERF_W = 32)
`endif
  ;
  import pipe_hazard_ctrl_pkg::*;

  logic [4:0]  id_rd_addr_a;
  logic [4:0]  id_rd_addr_b;
  logic        id_use_a;
  logic        id_use_b;
  logic        ex_mem_rd;
  logic [4:0]  ex_wr_addr;
  logic        ex_branch;
  logic        id_jump;
  logic        exc_badop;
  logic        exc_ovf;
  logic [31:0] exc_pc;
  logic        mem_req;
  logic        mem_ready;

  logic        pc_stall;
  logic        if_stall;
  logic        id_stall;
  logic        ex_stall;
  logic        mem_stall;
  logic        if_clear;
  logic        id_clear;
  logic        ex_clear;
  logic        mem_clear;
  pcsel_t      pc_sel;
  logic [31:0] epc;
  exc_cause_t  cause;
  logic        exc_busy;
`ifdef PERF_CNT_EN
  logic [PERF_W-1:0] perf_stall;
  logic [PERF_W-1:0] perf_flush;
  logic [PERF_W-1:0] perf_exc;
`endif

  modport master (
`ifdef PERF_CNT_EN
    output perf_stall, perf_flush, perf_exc,
`endif
    input  id_rd_addr_a, id_rd_addr_b, id_use_a, id_use_b,
           ex_mem_rd, ex_wr_addr, ex_branch, id_jump,
           exc_badop, exc_ovf, exc_pc, mem_req, mem_ready,
    output pc_stall, if_stall, id_stall, ex_stall, mem_stall,
           if_clear, id_clear, ex_clear, mem_clear,
           pc_sel, epc, cause, exc_busy
  );

  modport slave (
`ifdef PERF_CNT_EN
    input  perf_stall, perf_flush, perf_exc,
`endif
    output id_rd_addr_a, id_rd_addr_b, id_use_a, id_use_b,
           ex_mem_rd, ex_wr_addr, ex_branch, id_jump,
           exc_badop, exc_ovf, exc_pc, mem_req, mem_ready,
    input  pc_stall, if_stall, id_stall, ex_stall, mem_stall,
           if_clear, id_clear, ex_clear, mem_clear,
           pc_sel, epc, cause, exc_busy
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use detector.
//   i_ex_mem_rd/i_ex_wr_addr : load in EX and its destination
//   i_rd_addr_a/b, i_use_a/b : decode-stage source registers and usage
//   o_luse                   : decode must wait one cycle for the load data
module hazard_detect (
  input  logic       i_ex_mem_rd,
  input  logic [4:0] i_ex_wr_addr,
  input  logic [4:0] i_rd_addr_a,
  input  logic [4:0] i_rd_addr_b,
  input  logic       i_use_a,
  input  logic       i_use_b,
  output logic       o_luse
);

  logic w_hit_a;
  logic w_hit_b;

  assign w_hit_a = i_use_a && (i_rd_addr_a == i_ex_wr_addr);
  assign w_hit_b = i_use_b && (i_rd_addr_b == i_ex_wr_addr);
  // r0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign o_luse  = i_ex_mem_rd && (i_ex_wr_addr != 5'd0) && (w_hit_a || w_hit_b);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pipe_hazard_ctrl_if.master (hazard status in, stall/clear,
//              pc_sel, epc, cause, exc_busy out)
// Parameters: MEM_TIMEOUT (mem_ready wait limit), FLUSH_CYC (EXC_FLUSH length),
// PERF_W (counter width, only with PERF_CNT_EN).
// Optional feature macro: PERF_CNT_EN adds perf_stall/perf_flush/perf_exc.
import pipe_hazard_ctrl_pkg::*;

module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned FLUSH_CYC   = 2
`ifdef PERF_CNT_EN
  , parameter int unsigned PERF_W    = 32
`endif
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.master bus
);

  localparam int unsigned CNT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned FCNT_W = $clog2(FLUSH_CYC + 1);

  ctrl_state_t       r_state;
  ctrl_state_t       w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [FCNT_W-1:0] r_fcnt;
  logic [31:0]       r_epc;
  exc_cause_t        r_cause;
  logic              w_luse;
  logic              w_exc;
  logic              w_wait;
  logic              w_tmo;
  logic              w_flush_done;

  hazard_detect u_hazard_detect (
    .i_ex_mem_rd  (bus.ex_mem_rd),
    .i_ex_wr_addr (bus.ex_wr_addr),
    .i_rd_addr_a  (bus.id_rd_addr_a),
    .i_rd_addr_b  (bus.id_rd_addr_b),
    .i_use_a      (bus.id_use_a),
    .i_use_b      (bus.id_use_b),
    .o_luse       (w_luse)
  );

  assign w_exc        = bus.exc_ovf || bus.exc_badop;
  assign w_wait       = bus.mem_req && !bus.mem_ready;
  assign w_tmo        = (r_cnt == CNT_W'(MEM_TIMEOUT)) && !bus.mem_ready;
  assign w_flush_done = (r_fcnt == FCNT_W'(FLUSH_CYC));

  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RUN: begin
        if (w_exc)       w_next = EXC_FLUSH;
        else if (w_wait) w_next = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (bus.mem_ready) w_next = RUN;
        else if (w_tmo)    w_next = EXC_FLUSH;
      end
      EXC_FLUSH: if (w_flush_done) w_next = EXC_REDIR;
      EXC_REDIR: w_next = RUN;
      default:   w_next = RUN;
    endcase
  end

  always_comb begin
    bus.pc_stall  = 1'b0;
    bus.if_stall  = 1'b0;
    bus.id_stall  = 1'b0;
    bus.ex_stall  = 1'b0;
    bus.mem_stall = 1'b0;
    bus.if_clear  = 1'b0;
    bus.id_clear  = 1'b0;
    bus.ex_clear  = 1'b0;
    bus.mem_clear = 1'b0;
    bus.pc_sel    = PC_SEQ;
    unique case (r_state)
      RUN: begin
        // One if/else chain encodes the redirect priority; a taken branch
        // flushes decode, so the load-use bubble and jump are moot then.
        if (w_exc) begin
          bus.pc_stall = 1'b1;
          bus.if_clear = 1'b1;
          bus.id_clear = 1'b1;
          bus.ex_clear = 1'b1;
        end else if (w_wait) begin
          bus.pc_stall  = 1'b1;
          bus.if_stall  = 1'b1;
          bus.id_stall  = 1'b1;
          bus.ex_stall  = 1'b1;
          bus.mem_stall = 1'b1;
        end else if (bus.ex_branch) begin
          bus.pc_sel   = PC_BRANCH;
          bus.if_clear = 1'b1;
          bus.id_clear = 1'b1;
        end else if (w_luse) begin
          bus.pc_stall = 1'b1;
          bus.if_stall = 1'b1;
          bus.id_clear = 1'b1;
        end else if (bus.id_jump) begin
          bus.pc_sel   = PC_JUMP;
          bus.if_clear = 1'b1;
        end
      end
      MEM_WAIT: begin
        bus.pc_stall  = 1'b1;
        bus.if_stall  = 1'b1;
        bus.id_stall  = 1'b1;
        bus.ex_stall  = 1'b1;
        bus.mem_stall = 1'b1;
        bus.mem_clear = w_tmo;
      end
      EXC_FLUSH: begin
        bus.pc_stall = 1'b1;
        bus.if_clear = 1'b1;
        bus.id_clear = 1'b1;
        bus.ex_clear = 1'b1;
      end
      EXC_REDIR: begin
        bus.pc_sel   = PC_EXC;
        bus.if_clear = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.exc_busy = (r_state == EXC_FLUSH) || (r_state == EXC_REDIR);
  assign bus.epc      = r_epc;
  assign bus.cause    = r_cause;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_fcnt  <= '0;
      r_epc   <= '0;
      r_cause <= EXC_NONE;
    end else begin
      if (r_state == RUN && w_next == MEM_WAIT)
        r_cnt <= CNT_W'(1);
      else if (r_state == MEM_WAIT && r_cnt != '1)
        r_cnt <= r_cnt + CNT_W'(1);

      if (r_state != EXC_FLUSH && w_next == EXC_FLUSH)
        r_fcnt <= FCNT_W'(1);
      else if (r_state == EXC_FLUSH)
        r_fcnt <= r_fcnt + FCNT_W'(1);

      if (r_state == RUN && w_exc) begin
        r_epc   <= bus.exc_pc;
        r_cause <= bus.exc_ovf ? EXC_OVF : EXC_BADOP;
      end else if (r_state == MEM_WAIT && w_tmo) begin
        r_epc   <= bus.exc_pc;
        r_cause <= EXC_BUS;
      end
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.perf_stall <= '0;
      bus.perf_flush <= '0;
      bus.perf_exc   <= '0;
    end else begin
      if (bus.pc_stall)
        bus.perf_stall <= bus.perf_stall + PERF_W'(1);
      if (bus.if_clear || bus.id_clear || bus.ex_clear || bus.mem_clear)
        bus.perf_flush <= bus.perf_flush + PERF_W'(1);
      if (r_state != EXC_FLUSH && w_next == EXC_FLUSH)
        bus.perf_exc <= bus.perf_exc + PERF_W'(1);
    end
  end
`endif

endmodule
